// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential signed divider: datapath width,
// FSM state encoding, special-case result constants and a magnitude helper.
package seq_divider_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Quotient returned for a zero divisor (all ones, i.e. -1).
  localparam logic [DIV_W-1:0] DIV0_Q  = 32'hFFFF_FFFF;
  // Most negative 32-bit value; also the overflowing INT_MIN / -1 quotient.
  localparam logic [DIV_W-1:0] INT_MIN = 32'h8000_0000;

  // Unsigned magnitude of a two's complement value. INT_MIN maps to
  // 32'h80000000, which is exact when read as unsigned.
  function automatic logic [DIV_W-1:0] magnitude(input logic [DIV_W-1:0] v);
    return v[DIV_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference only
// when it is non-negative, and shift the resulting quotient bit in.
module div_step
  import seq_divider_pkg::*;
(
  input  logic [DIV_W-1:0] rem,
  input  logic [DIV_W-1:0] quo,
  input  logic [DIV_W-1:0] dvs,
  output logic [DIV_W-1:0] rem_next,
  output logic [DIV_W-1:0] quo_next
);

  logic [DIV_W:0] shifted;
  logic [DIV_W:0] trial;

  // Shift-subtract-select. The partial remainder always stays below the
  // divisor, so the selected value fits back into DIV_W bits.
  always_comb begin
    shifted = {rem, quo[DIV_W-1]};
    trial   = shifted - {1'b0, dvs};
    if (!trial[DIV_W]) begin
      rem_next = trial[DIV_W-1:0];
    end else begin
      rem_next = shifted[DIV_W-1:0];
    end
    quo_next = {quo[DIV_W-2:0], ~trial[DIV_W]};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed 32-bit divider. Magnitudes are divided one bit per cycle
// by restoring division, then signs are applied in a final FIX cycle.
// Divide-by-zero and INT_MIN / -1 skip the iteration with preloaded results.
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] A,
  input  logic [DIV_W-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] Q,
  output logic [DIV_W-1:0] R
);

  div_state_e       state_q, state_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] dvs_q, dvs_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;
  logic [DIV_W-1:0] q_q, q_d;
  logic [DIV_W-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIV_W-1:0] step_rem;
  logic [DIV_W-1:0] step_quo;

  div_step u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvs      (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Next-state logic for the FSM, datapath registers and registered outputs.
  // Special cases load their final magnitudes with both sign flags cleared,
  // so FIX passes them through unchanged.
  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          cnt_d  = 5'd31;
          dvs_d  = magnitude(B);
          if (B == '0) begin
            quo_d   = DIV0_Q;
            rem_d   = A;
            sq_d    = 1'b0;
            sr_d    = 1'b0;
            state_d = FIX;
          end else if ((A == INT_MIN) && (B == '1)) begin
            quo_d   = INT_MIN;
            rem_d   = '0;
            sq_d    = 1'b0;
            sr_d    = 1'b0;
            state_d = FIX;
          end else begin
            quo_d   = magnitude(A);
            rem_d   = '0;
            sq_d    = A[DIV_W-1] ^ B[DIV_W-1];
            sr_d    = A[DIV_W-1];
            state_d = CALC;
          end
        end
      end
      CALC: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        q_d     = sq_q ? -quo_q : quo_q;
        r_d     = sr_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Q    = q_q;
  assign R    = r_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes the expected quotient,
// remainder and completion cycle; a monitor pops and compares on every done.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] Q;
  logic [31:0] R;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_checks;
  int   n_pass;

  seq_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge counter used to measure latency
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic reportFail(input string name);
    n_checks++;
    $display("[TB] FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: truncating signed division in 64-bit arithmetic, with the
  // divide-by-zero convention Q = -1, R = A. INT_MIN / -1 wraps to INT_MIN.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    longint lq;
    longint lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      lq = sa / sb;
      lr = sa - lq * sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end
  endfunction

  // Issue one request at a falling edge once the divider is idle.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    int          guard;
    logic [31:0] eq;
    logic [31:0] er;
    exp_t        e;
    guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy) reportFail("idle_timeout");
    A     = a;
    B     = b;
    start = 1'b1;
    model(a, b, eq, er);
    e.q   = eq;
    e.r   = er;
    e.cyc = cyc + 1 + (((b == 32'd0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          reportFail("unexpected_done");
        end else begin
          e = exp_q.pop_front();
          checkOutput("Q", Q, e.q);
          checkOutput("R", R, e.r);
          checkOutput("done_cycle", cyc, e.cyc);
          checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  initial begin
    int          busy_cnt;
    int          guard;
    logic [31:0] ra;
    logic [31:0] rb;

    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    A        = '0;
    B        = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_Q", Q, 32'd0);
    checkOutput("reset_R", R, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 100 / 7 with busy duration measured, then a start in the done cycle
    applyStimulus(32'd100, 32'd7);
    busy_cnt = 0;
    while (busy && busy_cnt < 100) begin
      busy_cnt++;
      @(negedge clk);
    end
    checkOutput("busy_cycles", busy_cnt, 32'd33);
    checkOutput("done_after_busy", {31'd0, done}, 32'd1);
    applyStimulus(32'd100, 32'd7);

    // A start pulse while busy must be ignored
    applyStimulus(32'd100, 32'd7);
    repeat (4) @(negedge clk);
    A     = 32'd1;
    B     = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Sign combinations and the two special cases
    applyStimulus(32'hFFFF_FF9C, 32'd7);
    applyStimulus(32'd7, 32'hFFFF_FF9C);
    applyStimulus(32'd5, 32'd0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(32'h8000_0000, 32'd1);
    applyStimulus(32'h7FFF_FFFF, 32'h8000_0000);

    // Reset in the middle of a division
    applyStimulus(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_Q", Q, 32'd0);
    checkOutput("abort_R", R, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    applyStimulus(32'd1234, 32'hFFFF_FFFB);

    // Randomized operands, biased toward small divisors and INT_MIN
    for (int i = 0; i < 1500; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($signed($urandom_range(0, 40)) - 20);
      if ($urandom_range(0, 15) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) ra = 32'($signed($urandom_range(0, 2000)) - 1000);
      applyStimulus(ra, rb);
    end

    // Drain outstanding results, then watch for stray done pulses
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) reportFail("drain_timeout");
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
